// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for a shared big-endian byte-addressed data memory.
// Optional round-robin arbitration via `define DMEM_ARB_RR_EN (default: fixed priority r0 > r1).
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 4);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic                win_q, win_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic                rerr0_q, rerr0_d, rerr1_q, rerr1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                sel1;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic                req_err;
  logic [DATA_W-1:0]   resp_data;
`ifdef DMEM_ARB_RR_EN
  logic                ptr_q, ptr_d;
`endif

  // Winner select: sel1 = 1 means r1 is served this transaction.
  always_comb begin
`ifdef DMEM_ARB_RR_EN
    sel1 = r1_req & (~r0_req | ptr_q);
`else
    sel1 = ~r0_req;
`endif
    req_we    = sel1 ? r1_we    : r0_we;
    req_addr  = sel1 ? r1_addr  : r0_addr;
    req_wdata = sel1 ? r1_wdata : r0_wdata;
    req_err   = req_addr > MAX_ADDR;
    resp_data = (!we_q && !err_q) ? mem_rdata : '0;
  end

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    we_d        = we_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    rerr0_d     = 1'b0;
    rerr1_d     = 1'b0;
    rdata0_d    = '0;
    rdata1_d    = '0;
`ifdef DMEM_ARB_RR_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (r0_req || r1_req) begin
          win_d  = sel1;
          we_d   = req_we;
          err_d  = req_err;
          gnt0_d = ~sel1;
          gnt1_d = sel1;
          // Out-of-range requests never reach the memory bus.
          if (!req_err) begin
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wdata;
          end
`ifdef DMEM_ARB_RR_EN
          ptr_d = ~sel1;
`endif
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (win_q) begin
          rvalid1_d = 1'b1;
          rerr1_d   = err_q;
          rdata1_d  = resp_data;
        end else begin
          rvalid0_d = 1'b1;
          rerr0_d   = err_q;
          rdata0_d  = resp_data;
        end
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      win_q       <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rerr0_q     <= 1'b0;
      rerr1_q     <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
`ifdef DMEM_ARB_RR_EN
      ptr_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      we_q        <= we_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rerr0_q     <= rerr0_d;
      rerr1_q     <= rerr1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
`ifdef DMEM_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  // Strobes decode from state so an async reset kills an in-flight write at once.
  assign mem_write = (state_q == ACCESS) && !err_q && we_q;
  assign mem_read  = (state_q == ACCESS) && !err_q && !we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);

  assign r0_gnt    = gnt0_q;
  assign r1_gnt    = gnt1_q;
  assign r0_rvalid = rvalid0_q;
  assign r1_rvalid = rvalid1_q;
  assign r0_err    = rerr0_q;
  assign r1_err    = rerr1_q;
  assign r0_rdata  = rdata0_q;
  assign r1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a 128-byte big-endian memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
  logic [31:0] r0_addr = '0, r0_wdata = '0, r1_addr = '0, r1_wdata = '0;
  logic        r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read, busy;

  logic [7:0]  mem [0:127];
  logic        mem_ready = 1'b0;
  int          wr_cycles = 0;
  int          checks = 0;
  int          errors = 0;
  int          wr_before;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory: byte i holds i initially; writes commit on the posedge.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'(i);
      mem_ready <= 1'b1;
    end else if (mem_write) begin
      wr_cycles <= wr_cycles + 1;
      if (mem_addr < 32'd125) begin
        mem[mem_addr[6:0]]         <= mem_wdata[31:24];
        mem[mem_addr[6:0] + 7'd1]  <= mem_wdata[23:16];
        mem[mem_addr[6:0] + 7'd2]  <= mem_wdata[15:8];
        mem[mem_addr[6:0] + 7'd3]  <= mem_wdata[7:0];
      end
    end
  end

  always_comb begin
    mem_rdata = '0;
    if (mem_addr < 32'd125)
      mem_rdata = {mem[mem_addr[6:0]], mem[mem_addr[6:0] + 7'd1],
                   mem[mem_addr[6:0] + 7'd2], mem[mem_addr[6:0] + 7'd3]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  initial begin
    tick();
    tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_outs", {24'd0, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_err, r1_err,
                         mem_write, mem_read}, 32'd0);
    check("reset_rdata", r0_rdata | r1_rdata, 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    tick();

    // Single read by r0 at address 8
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'd8;
    tick();
    check("rd8_gnt", {30'd0, r0_gnt, r1_gnt}, 32'b10);
    check("rd8_mem_read", {30'd0, mem_read, mem_write}, 32'b10);
    check("rd8_mem_addr", mem_addr, 32'd8);
    check("rd8_busy", 32'(busy), 32'd1);
    r0_req = 1'b0;
    tick();
    check("rd8_rvalid", {30'd0, r0_rvalid, r0_err}, 32'b10);
    check("rd8_rdata", r0_rdata, 32'h08090A0B);
    check("rd8_strobes_off", {30'd0, mem_read, r0_gnt}, 32'd0);
    tick();
    check("rd8_idle", {30'd0, busy, r0_rvalid}, 32'd0);

    // r1 writes 0xDEADBEEF to address 4, then reads it back
    wr_before = wr_cycles;
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 32'd4; r1_wdata = 32'hDEADBEEF;
    tick();
    check("wr4_gnt", {30'd0, r0_gnt, r1_gnt}, 32'b01);
    check("wr4_mem_write", {30'd0, mem_write, mem_read}, 32'b10);
    check("wr4_mem_wdata", mem_wdata, 32'hDEADBEEF);
    r1_req = 1'b0;
    tick();
    check("wr4_rvalid", {30'd0, r1_rvalid, r1_err}, 32'b10);
    check("wr4_rdata", r1_rdata, 32'd0);
    tick();
    check("wr4_one_cycle", 32'(wr_cycles - wr_before), 32'd1);
    r1_req = 1'b1; r1_we = 1'b0;
    tick();
    r1_req = 1'b0;
    tick();
    check("rd4_rvalid", 32'(r1_rvalid), 32'd1);
    check("rd4_rdata", r1_rdata, 32'hDEADBEEF);
    tick();

    // Contention: both request continuously for four transactions
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'd0;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'd16;
    for (int k = 0; k < 4; k++) begin
      logic exp1;
`ifdef DMEM_ARB_RR_EN
      exp1 = (k % 2) == 1;
`else
      exp1 = 1'b0;
`endif
      tick();
      check($sformatf("cont%0d_gnt", k), {30'd0, r0_gnt, r1_gnt}, {30'd0, ~exp1, exp1});
      tick();
      check($sformatf("cont%0d_rvalid", k), {30'd0, r0_rvalid, r1_rvalid}, {30'd0, ~exp1, exp1});
      check($sformatf("cont%0d_rdata", k), exp1 ? r1_rdata : r0_rdata,
            exp1 ? 32'h10111213 : 32'h00010203);
      tick();
    end
    r0_req = 1'b0; r1_req = 1'b0;
    tick();

    // Out-of-range write at 125: no memory access, err response
    wr_before = wr_cycles;
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'd125; r0_wdata = 32'h11223344;
    tick();
    check("err_gnt", 32'(r0_gnt), 32'd1);
    check("err_no_strobe", {30'd0, mem_write, mem_read}, 32'd0);
    r0_req = 1'b0;
    tick();
    check("err_rvalid", {30'd0, r0_rvalid, r0_err}, 32'b11);
    check("err_rdata", r0_rdata, 32'd0);
    tick();
    check("err_no_write", 32'(wr_cycles - wr_before), 32'd0);
    check("err_mem_intact", {mem[124], mem[125], mem[126], mem[127]}, 32'h7C7D7E7F);

    // Boundary read at 124
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'd124;
    tick();
    r0_req = 1'b0;
    check("bnd_mem_read", 32'(mem_read), 32'd1);
    tick();
    check("bnd_rvalid", {30'd0, r0_rvalid, r0_err}, 32'b10);
    check("bnd_rdata", r0_rdata, 32'h7C7D7E7F);
    tick();

    // Reset during ACCESS of a write to address 0
    wr_before = wr_cycles;
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'd0; r0_wdata = 32'hAABBCCDD;
    tick();
    check("rst_pre_write", 32'(mem_write), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_write_drop", 32'(mem_write), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt", 32'(r0_gnt), 32'd0);
    r0_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("rst_no_rvalid_a", {30'd0, r0_rvalid, r1_rvalid}, 32'd0);
    tick();
    check("rst_no_rvalid_b", {30'd0, r0_rvalid, r1_rvalid}, 32'd0);
    check("rst_byte0", 32'(mem[0]), 32'd0);
    check("rst_no_write", 32'(wr_cycles - wr_before), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
